// File: rtl/spi_adc_sequencer.sv
// Periodic conversion scheduler for the SPI ADC engine with 2^AVG_LOG2 sample averaging.
// Optional watchdog on hung conversions is built in when ADC_TIMEOUT_EN is defined.
module spi_adc_sequencer #(
  parameter int unsigned DATA_W         = 12,
  parameter int unsigned PERIOD_CYCLES  = 1000,
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              spi_start,
  input  logic [DATA_W-1:0] spi_data,
  input  logic              spi_data_valid,
  output logic [DATA_W-1:0] avg_data,
  output logic              avg_valid,
  output logic              busy,
  output logic [7:0]        overrun_cnt,
  output logic              timeout
);

  localparam int unsigned CNT_W = $clog2(PERIOD_CYCLES);
  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] TICK_VAL = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'((2 ** AVG_LOG2) - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

`ifdef ADC_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;
  localparam logic [1:0] WAIT_TICK = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] period_cnt;
  logic [WD_W-1:0]  wd;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [SMP_W-1:0] smp_cnt;
  logic             tick, wd_expired;
  logic             accept, abort, drop;

  // Period counter reads k in the k-th cycle after a start, so starts land PERIOD_CYCLES apart
  assign tick       = (state != IDLE) && (period_cnt == TICK_VAL);
  assign wd_expired = TIMEOUT_EN && (wd == WD_LAST);
  assign sum        = acc + ACC_W'(spi_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle events
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    abort     = 1'b0;
    drop      = 1'b0;
    unique case (state)
      IDLE:  if (enable) state_nxt = START;
      START: state_nxt = WAIT_DATA;
      WAIT_DATA: begin
        if (spi_data_valid || wd_expired) begin
          // A sample completing after enable drops is not accumulated
          accept    = spi_data_valid && enable;
          abort     = !spi_data_valid;
          if (!enable)   state_nxt = IDLE;
          else if (tick) state_nxt = START;
          else           state_nxt = WAIT_TICK;
        end else if (tick) begin
          drop = 1'b1;
        end
      end
      WAIT_TICK: if (tick) state_nxt = enable ? START : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Registered outputs, counters and averaging datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_start   <= 1'b0;
      busy        <= 1'b0;
      avg_valid   <= 1'b0;
      avg_data    <= '0;
      overrun_cnt <= '0;
      timeout     <= 1'b0;
      period_cnt  <= '0;
      wd          <= '0;
      acc         <= '0;
      smp_cnt     <= '0;
    end else begin
      spi_start  <= (state_nxt == START);
      busy       <= (state_nxt == WAIT_DATA);
      timeout    <= abort;
      avg_valid  <= 1'b0;
      period_cnt <= (state == IDLE || tick) ? '0 : period_cnt + CNT_W'(1);

      if (state == START)          wd <= WD_W'(1);
      else if (state == WAIT_DATA) wd <= wd + WD_W'(1);

      if (drop && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;

      if (accept) begin
        if (smp_cnt == LAST_SMP) begin
          avg_data  <= DATA_W'(sum >> AVG_LOG2);
          avg_valid <= 1'b1;
          acc       <= '0;
          smp_cnt   <= '0;
        end else begin
          acc     <= sum;
          smp_cnt <= smp_cnt + SMP_W'(1);
        end
      end else if (state_nxt == IDLE) begin
        acc     <= '0;
        smp_cnt <= '0;
      end
    end
  end

endmodule
